oka_mult_pipe: RTL
==================

Name: oka_mult_pipe

Overview:
- Parametrised, pipelined Karatsuba multiplier; next generation of the 16-bit combinational OKA multiplier.
- Adds configurable operand width, a signed/unsigned mode, a 3-stage pipeline with valid/ready handshake on both sides, and an in-flight counter.
- Sits between operand producers (datapath or DMA feeder) and result consumers; sustains one product per cycle when the output is not back-pressured.

Parameters:
- WIDTH, 16, operand width in bits; even, >= 4; h = WIDTH/2.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product this cycle
- y  out  2*WIDTH  product A*B, full width, no truncation
- inflight  out  2  number of valid pipeline entries, 0..3

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, y = 0, inflight = 0. Datapath registers are don't-care, except y.
- Global pipeline enable: en = ~out_valid | out_ready; in_ready = en (combinational).
- Accept: an operand pair is accepted when in_valid & in_ready.
- When en = 0, all stages hold and in_valid is ignored.
- Stage 1 (registered on accept):
  - SIGNED = 1: store sign = a[MSB]^b[MSB], and store |a|, |b| as WIDTH-bit magnitudes. -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1).
  - SIGNED = 0: sign = 0, magnitudes = a, b.
- Stage 2:
  - Split each magnitude: xH = x[WIDTH-1:h], xL = x[h-1:0].
  - Register z0 = aL*bL (2h bits) and z2 = aH*bH (2h bits).
  - Register zm = (aH+aL)*(bH+bL) with (h+1)-bit sums and a 2h+2-bit product.
- Stage 3:
  - z1 = zm - z0 - z2, computed at 2h+2 bits; never negative.
  - p = (z2 << WIDTH) + (z1 << h) + z0, 2*WIDTH bits.
  - y = sign ? -p : p, modulo 2^(2*WIDTH). Register y; set out_valid.
- Latency: exactly 3 enabled cycles from accept to out_valid. With out_ready held high, a pair accepted on cycle n gives a product on cycle n+3, with full throughput.
- Valid bits advance only when en = 1; a stage with valid = 0 is a bubble and flows through. Stall is global, with no bubble collapsing.
- Output handshake:
  - y and out_valid stay stable while out_valid & ~out_ready.
  - A transfer occurs when out_valid & out_ready.
  - If no new result arrives in that cycle, out_valid falls next cycle.
- inflight = count of set valid bits across stages 1-3, updated every cycle.
- Simultaneous accept and output transfer in one cycle is legal; inflight is unchanged.
- Reset asserted mid-operation discards all in-flight entries immediately. No product is emitted for them after release.
- Unused bits: none. The product of two WIDTH-bit operands always fits 2*WIDTH bits in both modes.

Test Plan:
- Unsigned single op, WIDTH=16: a=63000, b=61000, out_ready=1 -> y=0xE50F86C0 (3843000000) exactly 3 cycles after accept; inflight goes 1,1,1 then 0.
- Unsigned corners, WIDTH=16: 65535*65535 -> 0xFFFE0001; 0*12345 -> 0; 1*65535 -> 0x0000FFFF.
- Signed, WIDTH=16, SIGNED=1:
  - -1*-1 -> 0x00000001
  - -32768*-32768 -> 0x40000000
  - -32768*32767 -> 0xC0008000
  - 5*-3 -> 0xFFFFFFF1
- Back-pressure: stream 4 back-to-back pairs (1*2, 3*4, 5*6, 7*8) and hold out_ready=0 after the first out_valid -> y holds 2, in_ready=0, inflight=3. Release out_ready -> outputs 2, 12, 30, 56 in order, with none lost or duplicated.
- Reset mid-operation: accept 2 pairs, assert rst_n=0 for 1 cycle asynchronously between clock edges -> out_valid=0, y=0, inflight=0 at once. No product appears afterwards.
- Parametric sweep: WIDTH=8 and WIDTH=32, both modes, 10k random pairs with random in_valid/out_ready -> every y matches a reference model, in order.

Source files
------------

// File: rtl/oka_mult_pipe.sv
// Three-stage pipelined Karatsuba multiplier with valid/ready handshake on both sides.
// Optional two's-complement mode works on magnitudes and negates the product at the end.
module oka_mult_pipe #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic [1:0]           inflight
);

  localparam int H  = WIDTH / 2;
  localparam int ZW = 2 * H + 2;
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};

  // Absolute value; the most negative input maps onto 2^(WIDTH-1) as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    if (SIGNED && x[WIDTH-1]) begin
      m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

  logic              v1_q, v1_d, s1_q, s1_d;
  logic [WIDTH-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic              v2_q, v2_d, s2_q, s2_d;
  logic [2*H-1:0]    z0_q, z0_d, z2_q, z2_d;
  logic [ZW-1:0]     zm_q, zm_d;
  logic              v3_q, v3_d;
  logic [PW-1:0]     y_q, y_d;
  logic [1:0]        inflight_q, inflight_d;

  logic              en_s;
  logic [H-1:0]      a_hi_s, a_lo_s, b_hi_s, b_lo_s;
  logic [H:0]        a_sum_s, b_sum_s;
  logic [ZW-1:0]     z1_s;
  logic [PW-1:0]     p_s;

  assign en_s     = ~v3_q | out_ready;
  assign in_ready = en_s;

  assign a_hi_s  = ma_q[WIDTH-1:H];
  assign a_lo_s  = ma_q[H-1:0];
  assign b_hi_s  = mb_q[WIDTH-1:H];
  assign b_lo_s  = mb_q[H-1:0];
  assign a_sum_s = {1'b0, a_hi_s} + {1'b0, a_lo_s};
  assign b_sum_s = {1'b0, b_hi_s} + {1'b0, b_lo_s};

  // z1 is the middle Karatsuba term; zm always dominates z0 + z2 so no borrow escapes.
  assign z1_s = zm_q - {2'b00, z0_q} - {2'b00, z2_q};
  assign p_s  = (PW'(z2_q) << WIDTH) + (PW'(z1_s) << H) + PW'(z0_q);

  // Next-state for all stages; a single global enable stalls the whole pipe.
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    ma_d = ma_q;
    mb_d = mb_q;
    v2_d = v2_q;
    s2_d = s2_q;
    z0_d = z0_q;
    z2_d = z2_q;
    zm_d = zm_q;
    v3_d = v3_q;
    y_d  = y_q;
    if (en_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d = SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
        ma_d = magnitude(a);
        mb_d = magnitude(b);
      end else begin
        s1_d = s1_q;
      end
      v2_d = v1_q;
      if (v1_q) begin
        s2_d = s1_q;
        z0_d = {{H{1'b0}}, a_lo_s} * {{H{1'b0}}, b_lo_s};
        z2_d = {{H{1'b0}}, a_hi_s} * {{H{1'b0}}, b_hi_s};
        zm_d = {{(H+1){1'b0}}, a_sum_s} * {{(H+1){1'b0}}, b_sum_s};
      end else begin
        s2_d = s2_q;
      end
      v3_d = v2_q;
      if (v2_q) begin
        y_d = s2_q ? (~p_s + ONE_P) : p_s;
      end else begin
        y_d = y_q;
      end
    end else begin
      v1_d = v1_q;
    end
    inflight_d = {1'b0, v1_d} + {1'b0, v2_d} + {1'b0, v3_d};
  end

  // Pipeline registers; reset drops every in-flight entry and clears the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      s1_q       <= 1'b0;
      ma_q       <= {WIDTH{1'b0}};
      mb_q       <= {WIDTH{1'b0}};
      v2_q       <= 1'b0;
      s2_q       <= 1'b0;
      z0_q       <= {(2*H){1'b0}};
      z2_q       <= {(2*H){1'b0}};
      zm_q       <= {ZW{1'b0}};
      v3_q       <= 1'b0;
      y_q        <= {PW{1'b0}};
      inflight_q <= 2'd0;
    end else begin
      v1_q       <= v1_d;
      s1_q       <= s1_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      v2_q       <= v2_d;
      s2_q       <= s2_d;
      z0_q       <= z0_d;
      z2_q       <= z2_d;
      zm_q       <= zm_d;
      v3_q       <= v3_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
    end
  end

  assign out_valid = v3_q;
  assign y         = y_q;
  assign inflight  = inflight_q;

endmodule
